// File: rtl/maquina_pkg.sv
// ============================================================================
// maquina_pkg
// Phase codes shared by the wash sequencer and the actuator-driver block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package maquina_pkg;

    localparam logic [2:0] FASE_IDLE       = 3'd0;
    localparam logic [2:0] FASE_ENCHER     = 3'd1;
    localparam logic [2:0] FASE_LAVAGEM    = 3'd2;
    localparam logic [2:0] FASE_ENXAGUE    = 3'd3;
    localparam logic [2:0] FASE_CENTRIFUGA = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE       = FASE_IDLE,
        ST_ENCHER     = FASE_ENCHER,
        ST_LAVAGEM    = FASE_LAVAGEM,
        ST_ENXAGUE    = FASE_ENXAGUE,
        ST_CENTRIFUGA = FASE_CENTRIFUGA
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/temporizador_fase.sv
// ============================================================================
// temporizador_fase
// Tick prescaler plus loadable down-counter timing one wash phase.
// Revision: 1.0
// ============================================================================
`default_nettype none

module temporizador_fase #(
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             carga,
    input  logic [CNT_W-1:0] valor,
    input  logic             pausa,
    output logic [CNT_W-1:0] tempo_restante,
    output logic             fim
);

    localparam int              PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre;
    logic             tick;

    assign tick = (pre == PRE_MAX);

    // A zero-length phase ends immediately; otherwise the 1->0 tick ends it.
    assign fim = !pausa && ((tempo_restante == '0) ||
                            (tick && (tempo_restante == CNT_W'(1))));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre            <= '0;
            tempo_restante <= '0;
        end else if (carga) begin
            pre            <= '0;
            tempo_restante <= valor;
        end else if (!pausa) begin
            if (tick) begin
                pre <= '0;
                if (tempo_restante != '0)
                    tempo_restante <= tempo_restante - CNT_W'(1);
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ciclo_lavagem.sv
// ============================================================================
// ciclo_lavagem
// Programmable wash cycle: fill, wash, N rinses, spin, with pause and abort.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ciclo_lavagem
    import maquina_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 1,
    parameter int NENX_W   = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              pausa,
    input  logic              abortar,
    input  logic [CNT_W-1:0]  t_encher,
    input  logic [CNT_W-1:0]  t_lavagem,
    input  logic [CNT_W-1:0]  t_enxague,
    input  logic [CNT_W-1:0]  t_centrifuga,
    input  logic [NENX_W-1:0] n_enxague,
    output logic              valvula_ativa,
    output logic              lavagem_ativa,
    output logic              enxague_ativa,
    output logic              centrifuga_ativa,
    output logic [2:0]        fase,
    output logic              ocupado,
    output logic              concluido,
    output logic [CNT_W-1:0]  tempo_restante
);

    estado_t             estado, prox;
    logic [CNT_W-1:0]    t_lav_r, t_enx_r, t_cen_r;
    logic [NENX_W-1:0]   n_cnt, n_prox;
    logic                nao_nula_r;
    logic                carga, latch, conc_prox, fim, nao_nula_prox;
    logic [CNT_W-1:0]    valor;

    temporizador_fase #(
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE)
    ) u_temporizador (
        .clock          (clock),
        .reset_n        (reset_n),
        .carga          (carga),
        .valor          (valor),
        .pausa          (pausa || (estado == ST_IDLE)),
        .tempo_restante (tempo_restante),
        .fim            (fim)
    );

    always_comb begin
        prox      = estado;
        carga     = 1'b0;
        valor     = '0;
        n_prox    = n_cnt;
        latch     = 1'b0;
        conc_prox = 1'b0;
        if (abortar) begin
            prox   = ST_IDLE;
            carga  = 1'b1;
            n_prox = '0;
        end else begin
            case (estado)
                ST_IDLE: begin
                    if (start) begin
                        prox   = ST_ENCHER;
                        carga  = 1'b1;
                        valor  = t_encher;
                        latch  = 1'b1;
                        n_prox = n_enxague;
                    end
                end
                ST_ENCHER: begin
                    if (fim) begin
                        prox  = ST_LAVAGEM;
                        carga = 1'b1;
                        valor = t_lav_r;
                    end
                end
                ST_LAVAGEM: begin
                    if (fim) begin
                        carga = 1'b1;
                        if (n_cnt != '0) begin
                            prox  = ST_ENXAGUE;
                            valor = t_enx_r;
                        end else begin
                            prox  = ST_CENTRIFUGA;
                            valor = t_cen_r;
                        end
                    end
                end
                ST_ENXAGUE: begin
                    if (fim) begin
                        carga  = 1'b1;
                        n_prox = n_cnt - NENX_W'(1);
                        if (n_cnt != NENX_W'(1)) begin
                            prox  = ST_ENXAGUE;
                            valor = t_enx_r;
                        end else begin
                            prox  = ST_CENTRIFUGA;
                            valor = t_cen_r;
                        end
                    end
                end
                ST_CENTRIFUGA: begin
                    if (fim) begin
                        prox      = ST_IDLE;
                        carga     = 1'b1;
                        conc_prox = 1'b1;
                    end
                end
                default: begin
                    prox  = ST_IDLE;
                    carga = 1'b1;
                end
            endcase
        end
    end

    // Whether the phase being entered (or continued) has a nonzero duration.
    assign nao_nula_prox = carga ? (valor != '0) : nao_nula_r;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado           <= ST_IDLE;
            n_cnt            <= '0;
            t_lav_r          <= '0;
            t_enx_r          <= '0;
            t_cen_r          <= '0;
            nao_nula_r       <= 1'b0;
            concluido        <= 1'b0;
            valvula_ativa    <= 1'b0;
            lavagem_ativa    <= 1'b0;
            enxague_ativa    <= 1'b0;
            centrifuga_ativa <= 1'b0;
        end else begin
            estado     <= prox;
            n_cnt      <= n_prox;
            nao_nula_r <= nao_nula_prox;
            concluido  <= conc_prox;
            if (latch) begin
                t_lav_r <= t_lavagem;
                t_enx_r <= t_enxague;
                t_cen_r <= t_centrifuga;
            end
            valvula_ativa    <= (prox == ST_ENCHER)     && !pausa && nao_nula_prox;
            lavagem_ativa    <= (prox == ST_LAVAGEM)    && !pausa && nao_nula_prox;
            enxague_ativa    <= (prox == ST_ENXAGUE)    && !pausa && nao_nula_prox;
            centrifuga_ativa <= (prox == ST_CENTRIFUGA) && !pausa && nao_nula_prox;
        end
    end

    assign fase    = estado;
    assign ocupado = (estado != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ciclo_lavagem.sv
// ============================================================================
// tb_ciclo_lavagem
// Directed and random stimulus against a phase-list reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ciclo_lavagem;

    localparam int CNT_W    = 8;
    localparam int PRESCALE = 2;
    localparam int NENX_W   = 2;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0, pausa = 1'b0, abortar = 1'b0;
    logic [CNT_W-1:0]  t_encher = '0, t_lavagem = '0, t_enxague = '0, t_centrifuga = '0;
    logic [NENX_W-1:0] n_enxague = '0;
    logic              valvula_ativa, lavagem_ativa, enxague_ativa, centrifuga_ativa;
    logic [2:0]        fase;
    logic              ocupado, concluido;
    logic [CNT_W-1:0]  tempo_restante;

    ciclo_lavagem #(
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE),
        .NENX_W   (NENX_W)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .pausa            (pausa),
        .abortar          (abortar),
        .t_encher         (t_encher),
        .t_lavagem        (t_lavagem),
        .t_enxague        (t_enxague),
        .t_centrifuga     (t_centrifuga),
        .n_enxague        (n_enxague),
        .valvula_ativa    (valvula_ativa),
        .lavagem_ativa    (lavagem_ativa),
        .enxague_ativa    (enxague_ativa),
        .centrifuga_ativa (centrifuga_ativa),
        .fase             (fase),
        .ocupado          (ocupado),
        .concluido        (concluido),
        .tempo_restante   (tempo_restante)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the programmed cycle as a list of (phase code, ticks).
    bit m_busy, m_conc, m_pau;
    int m_code[8];
    int m_T[8];
    int m_n, m_idx, m_el;

    task automatic model_reset();
        m_busy = 0; m_conc = 0; m_pau = 0; m_n = 0; m_idx = 0; m_el = 0;
    endtask

    function automatic int fase_len(int t);
        return (t == 0) ? 1 : t * PRESCALE;
    endfunction

    task automatic model_edge(input bit s, input bit p, input bit a);
        m_conc = 0;
        m_pau  = p;
        if (a) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (s) begin
                m_n = 0;
                m_code[m_n] = 1; m_T[m_n] = int'(t_encher);  m_n++;
                m_code[m_n] = 2; m_T[m_n] = int'(t_lavagem); m_n++;
                for (int r = 0; r < int'(n_enxague); r++) begin
                    m_code[m_n] = 3; m_T[m_n] = int'(t_enxague); m_n++;
                end
                m_code[m_n] = 4; m_T[m_n] = int'(t_centrifuga); m_n++;
                m_busy = 1; m_idx = 0; m_el = 0;
            end
        end else if (!p) begin
            m_el++;
            if (m_el == fase_len(m_T[m_idx])) begin
                m_idx++;
                m_el = 0;
                if (m_idx == m_n) begin
                    m_busy = 0;
                    m_conc = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        int ef, et;
        ef = m_busy ? m_code[m_idx] : 0;
        et = (m_busy && m_T[m_idx] != 0) ? m_T[m_idx] - m_el / PRESCALE : 0;
        verifica("fase", 32'(fase), 32'(ef));
        verifica("tempo_restante", 32'(tempo_restante), 32'(et));
        verifica("ocupado", 32'(ocupado), 32'(m_busy));
        verifica("concluido", 32'(concluido), 32'(m_conc));
        verifica("valvula_ativa", 32'(valvula_ativa),
                 32'(ef == 1 && !m_pau && m_busy && m_T[m_idx] != 0));
        verifica("lavagem_ativa", 32'(lavagem_ativa),
                 32'(ef == 2 && !m_pau && m_busy && m_T[m_idx] != 0));
        verifica("enxague_ativa", 32'(enxague_ativa),
                 32'(ef == 3 && !m_pau && m_busy && m_T[m_idx] != 0));
        verifica("centrifuga_ativa", 32'(centrifuga_ativa),
                 32'(ef == 4 && !m_pau && m_busy && m_T[m_idx] != 0));
    endtask

    task automatic step();
        @(posedge clock);
        if (!reset_n) model_reset();
        else          model_edge(start, pausa, abortar);
        #1;
        compare_all();
    endtask

    task automatic programa(input int te, input int tl, input int tx, input int tc, input int n);
        t_encher     = CNT_W'(te);
        t_lavagem    = CNT_W'(tl);
        t_enxague    = CNT_W'(tx);
        t_centrifuga = CNT_W'(tc);
        n_enxague    = NENX_W'(n);
    endtask

    // Counts edges after the start edge until concluido is seen; -1 on timeout.
    task automatic ate_concluir(output int n);
        n = -1;
        for (int e = 1; e <= 300; e++) begin
            step();
            if (concluido) begin
                n = e;
                return;
            end
        end
    endtask

    int n_ed;

    initial begin
        model_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;

        // Nominal cycle, durations changed after start must not matter.
        programa(3, 4, 2, 3, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        programa(7, 7, 7, 7, 1);
        ate_concluir(n_ed);
        verifica("len_nominal", 32'(n_ed), 32'd28);

        // Pause of 5 edges inside LAVAGEM while tempo_restante is 3.
        programa(3, 4, 2, 3, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 0; e < 8; e++) step();
        verifica("pausa_tempo_ini", 32'(tempo_restante), 32'd3);
        pausa = 1'b1;
        for (int e = 0; e < 5; e++) step();
        verifica("pausa_tempo_hold", 32'(tempo_restante), 32'd3);
        verifica("pausa_lavagem_off", 32'(lavagem_ativa), 32'd0);
        pausa = 1'b0;
        ate_concluir(n_ed);
        verifica("len_pausa", 32'(n_ed + 13), 32'd33);

        // Zero-length wash and no rinse.
        programa(3, 0, 2, 3, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        ate_concluir(n_ed);
        verifica("len_zero_lav", 32'(n_ed), 32'd13);

        // Abort together with start during ENXAGUE, then a full cycle.
        programa(3, 4, 2, 3, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 0; e < 40 && fase != 3'd3; e++) step();
        verifica("abort_na_enxague", 32'(fase), 32'd3);
        abortar = 1'b1;
        start   = 1'b1;
        step();
        verifica("abort_fase", 32'(fase), 32'd0);
        verifica("abort_tempo", 32'(tempo_restante), 32'd0);
        abortar = 1'b0;
        step();
        start = 1'b0;
        ate_concluir(n_ed);
        verifica("len_pos_abort", 32'(n_ed), 32'd28);

        // Random traffic, with occasional asynchronous reset mid-cycle.
        for (int i = 0; i < 4000; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            pausa   = ($urandom_range(0, 7) == 0);
            abortar = ($urandom_range(0, 99) == 0);
            programa($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                     $urandom_range(0, 4), $urandom_range(0, 3));
            if (!reset_n) reset_n = 1'b1;
            if ($urandom_range(0, 199) == 0 && ocupado) begin
                #2;
                reset_n = 1'b0;
                #1;
                model_reset();
                compare_all();
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ciclo_lavagem.md
# ciclo_lavagem

Parametrised wash-cycle sequencer. It extends the single fixed-length wash timer into a complete programmable cycle: fill, wash, N rinses, then spin. Per-phase durations are counted in prescaled ticks, with pause and abort controls. It sits between the front-panel control logic and the actuator drivers (valve, drum motor, spin motor).

## Interface
- `CNT_W`, 8: width of phase duration inputs and the remaining-time counter.
- `PRESCALE`, 1: clock cycles per time tick (≥1).
- `NENX_W`, 2: width of the rinse-repeat count.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: sampled in IDLE; begins a cycle.
- `pausa` in 1: level; freezes timing and gates actuators.
- `abortar` in 1: level; returns to IDLE.
- `t_encher`, `t_lavagem`, `t_enxague`, `t_centrifuga` in CNT_W each: phase durations in ticks.
- `n_enxague` in NENX_W: number of rinse repetitions (0 = no rinse).
- `valvula_ativa`, `lavagem_ativa`, `enxague_ativa`, `centrifuga_ativa` out 1 each: actuator enables.
- `fase` out 3: current phase code.
- `ocupado` out 1: high whenever not IDLE.
- `concluido` out 1: one-cycle completion pulse.
- `tempo_restante` out CNT_W: ticks left in the current phase.

## Operation
- States and codes: IDLE=0, ENCHER=1, LAVAGEM=2, ENXAGUE=3, CENTRIFUGA=4. Codes 5–7 are illegal and recover to IDLE.
- Start:
  - IDLE with `start`=1 latches all four durations and `n_enxague`.
  - It loads `tempo_restante` with `t_encher` and enters ENCHER.
  - Later changes to these inputs have no effect until the next start.
  - `start` is ignored outside IDLE.
- Sequence:
  - ENCHER → LAVAGEM.
  - LAVAGEM → ENXAGUE if the latched rinse count > 0, else → CENTRIFUGA.
  - ENXAGUE decrements the rinse count at phase end; it re-enters ENXAGUE (reloading `t_enxague`) while the count is nonzero, else → CENTRIFUGA.
  - CENTRIFUGA → IDLE, with `concluido`=1 for that single IDLE entry cycle.
- Phase timing:
  - A prescaler counts 0..PRESCALE-1 and clears on every phase entry; a tick fires when it reaches PRESCALE-1.
  - Each tick decrements `tempo_restante`.
  - The tick that takes it from 1 to 0 causes the transition on that same edge, and the next phase is loaded.
- Zero duration: a phase programmed to 0 occupies exactly one clock cycle with its actuator output low and `tempo_restante`=0, then advances.
- Actuator outputs:
  - Each is decoded from the state register (Moore, no input-to-output paths).
  - Each is high only in its own phase while `pausa`=0 and the phase duration is nonzero.
- Pause:
  - While `pausa`=1 in a non-IDLE state, the prescaler, `tempo_restante` and the rinse count hold.
  - All actuator outputs are 0; `fase` and `ocupado` are unchanged.
  - On release, counting resumes from the held values.
  - `pausa` has no effect in IDLE.
- Abort:
  - `abortar`=1 on any edge forces IDLE and clears `tempo_restante`; `concluido` is not pulsed.
  - Abort has priority over `start`, `pausa` and phase completion.

## Timing
- Reset values: `fase`=IDLE, `tempo_restante`=0, all actuator outputs 0, `ocupado`=0, `concluido`=0; prescaler and rinse count 0.
- Start latency: `start` is sampled at edge k; `fase`=ENCHER and `valvula_ativa`=1 are visible after edge k.
- Phase length: T·PRESCALE cycles for T>0 (paused cycles excluded); 1 cycle for T=0.
- `concluido` is high for exactly one cycle. `start` in that same cycle is accepted and starts a new cycle.
- Asserting reset mid-cycle returns to reset values immediately. No state survives reset.

## Structure
- Package `maquina_pkg`: phase code constants (`FASE_IDLE`…`FASE_CENTRIFUGA`). The actuator-drivers block shares these.
- Sub-module `temporizador_fase`: prescaler plus loadable down-counter.
  - Inputs: `carga`, `valor`, `pausa`.
  - Outputs: `tempo_restante`, `fim` (last tick).
- Top level: the FSM, the rinse counter, and output decode.

## Test plan
- PRESCALE=2, t=3/4/2/3, `n_enxague`=2, start at edge 0 → fase 1 from edge 0 to edge 6, 2 to edge 14, 3 to edge 18, 3 to edge 22, 4 to edge 28; `concluido` high only for the cycle after edge 28.
- `n_enxague`=0 → LAVAGEM goes directly to CENTRIFUGA; `enxague_ativa` never asserts.
- `t_lavagem`=0 → LAVAGEM lasts 1 cycle with `lavagem_ativa`=0 and `tempo_restante`=0.
- `pausa` high for 5 cycles during LAVAGEM (PRESCALE=2, `tempo_restante`=3) → all actuators 0, `tempo_restante` holds 3; total cycle length grows by 5 cycles.
- `abortar` pulsed during ENXAGUE together with `start` → IDLE next edge, `tempo_restante`=0, no `concluido`; the next `start` runs a full cycle.
- Reset asserted asynchronously mid-CENTRIFUGA → outputs go to reset values before the next edge; `start` held in ENCHER is ignored until IDLE.
